// File: rtl/nn_frame_buffer_pkg.sv
// Shared constants and types for the nn_frame_buffer slice.
// Frame size, feature width, network latency, FSM state encodings.
package nn_frame_buffer_pkg;

   localparam int IN_SIZE_1  = 13;
   localparam int FEAT_W     = 16;
   localparam int NN_LATENCY = 4;

   typedef logic signed [FEAT_W-1:0] feat_vec_t [IN_SIZE_1];

   typedef enum logic {
      W_FILL,
      W_FULL
   } wr_state_t;

   typedef enum logic {
      R_IDLE,
      R_WAIT
   } rd_state_t;

endpackage

// File: rtl/nn_frame_buffer_if.sv
// Serial feature stream with valid/ready handshake.
// master: feature source; slave: nn_frame_buffer (drives feat_ready).
interface nn_frame_buffer_if
#(
   parameter int W = nn_frame_buffer_pkg::FEAT_W
);
   import nn_frame_buffer_pkg::*;

   logic signed [W-1:0] feat_in;
   logic                feat_valid;
   logic                feat_last;
   logic                feat_ready;

   modport master (
      output feat_in,
      output feat_valid,
      output feat_last,
      input  feat_ready
   );

   modport slave (
      input  feat_in,
      input  feat_valid,
      input  feat_last,
      output feat_ready
   );

endinterface

// File: rtl/nn_frame_buffer_result_timer.sv
// nn_result_timer: times the network latency after a bank swap and
// samples the class result. Ports: clk, rst, i_swap (swap edge),
// i_nn_class, o_class_out/o_class_valid (result), o_swap_ok (permit).
module nn_result_timer
#(
   parameter int NN_LATENCY = nn_frame_buffer_pkg::NN_LATENCY
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       i_swap,
   input  logic [1:0] i_nn_class,
   output logic [1:0] o_class_out,
   output logic       o_class_valid,
   output logic       o_swap_ok
);
   import nn_frame_buffer_pkg::*;

   localparam int CW = $clog2(NN_LATENCY + 1);
   localparam logic [CW-1:0] LOAD = CW'(NN_LATENCY);
   localparam logic [CW-1:0] ONE  = CW'(1);

   rd_state_t       r_st;
   logic [CW-1:0]   r_cnt;
   logic [1:0]      r_cls;
   logic            r_cv;
   logic            w_hit;

   // Sampling edge: the result of the frame shown since the swap is ready.
   assign w_hit = (r_st == R_WAIT) && (r_cnt == ONE);

   // A new frame may be shown once the previous one is sampled.
   assign o_swap_ok     = (r_st == R_IDLE) || w_hit;
   assign o_class_out   = r_cls;
   assign o_class_valid = r_cv;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_st  <= R_IDLE;
         r_cnt <= '0;
         r_cls <= '0;
         r_cv  <= 1'b0;
      end else begin
         r_cv <= w_hit;
         if (w_hit)
            r_cls <= i_nn_class;
         // A swap on the sampling edge reloads and keeps waiting.
         if (i_swap) begin
            r_cnt <= LOAD;
            r_st  <= R_WAIT;
         end else if (r_st == R_WAIT) begin
            if (w_hit) begin
               r_cnt <= '0;
               r_st  <= R_IDLE;
            end else begin
               r_cnt <= r_cnt - 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/nn_frame_buffer.sv
// Ping-pong frame collector feeding top_nn, plus result timing.
// Ports: clk, rst, feat (stream slave), nn_vector, nn_class,
// class_out, class_valid, frame_err.
module nn_frame_buffer
#(
   parameter int IN_SIZE    = nn_frame_buffer_pkg::IN_SIZE_1,
   parameter int FEAT_W     = nn_frame_buffer_pkg::FEAT_W,
   parameter int NN_LATENCY = nn_frame_buffer_pkg::NN_LATENCY
)
(
   input  logic                     clk,
   input  logic                     rst,
   nn_frame_buffer_if.slave         feat,
   output logic signed [FEAT_W-1:0] nn_vector [IN_SIZE],
   input  logic [1:0]               nn_class,
   output logic [1:0]               class_out,
   output logic                     class_valid,
   output logic                     frame_err
);
   import nn_frame_buffer_pkg::*;

   localparam int IW = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(IN_SIZE - 1);

   logic signed [FEAT_W-1:0] r_bank0 [IN_SIZE];
   logic signed [FEAT_W-1:0] r_bank1 [IN_SIZE];
   logic [IW-1:0]            r_idx;
   logic                     r_sel;
   wr_state_t                r_wst;
   logic                     r_err;

   logic w_acc;
   logic w_at_end;
   logic w_swap_ok;
   logic w_swap;

   assign w_acc    = (r_wst == W_FILL) && feat.feat_valid;
   assign w_at_end = (r_idx == LAST_IDX);
   assign w_swap   = (r_wst == W_FULL) && w_swap_ok;

   assign feat.feat_ready = (r_wst == W_FILL);
   assign frame_err       = r_err;

   // r_sel names the displayed bank; the other one fills.
   always_comb begin
      for (int i = 0; i < IN_SIZE; i++)
         nn_vector[i] = r_sel ? r_bank1[i] : r_bank0[i];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < IN_SIZE; i++) begin
            r_bank0[i] <= '0;
            r_bank1[i] <= '0;
         end
         r_idx <= '0;
         r_sel <= 1'b0;
         r_wst <= W_FILL;
         r_err <= 1'b0;
      end else begin
         r_err <= 1'b0;
         if (w_swap) begin
            r_sel <= ~r_sel;
            r_wst <= W_FILL;
         end
         if (w_acc) begin
            if (r_sel)
               r_bank0[r_idx] <= feat.feat_in;
            else
               r_bank1[r_idx] <= feat.feat_in;
            // Misframed words stay in the hidden bank and get overwritten.
            if (feat.feat_last && w_at_end) begin
               r_wst <= W_FULL;
               r_idx <= '0;
            end else if (feat.feat_last || w_at_end) begin
               r_err <= 1'b1;
               r_idx <= '0;
            end else begin
               r_idx <= r_idx + 1'b1;
            end
         end
      end
   end

   nn_result_timer #(
      .NN_LATENCY (NN_LATENCY)
   ) u_timer (
      .clk           (clk),
      .rst           (rst),
      .i_swap        (w_swap),
      .i_nn_class    (nn_class),
      .o_class_out   (class_out),
      .o_class_valid (class_valid),
      .o_swap_ok     (w_swap_ok)
   );

endmodule
